// File: rtl/axi_inst_rom_slave.sv
// rtl/axi_inst_rom_slave.sv - AXI3 read-only instruction ROM slave with SLVERR write rejection
module axi_inst_rom_slave #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] rom_mem [0:(1<<ADDR_BITS)-1];

    r_state_t r_state, r_state_nxt;
    w_state_t w_state, w_state_nxt;

    logic [3:0]           lat_cnt;
    logic [3:0]           id_q;
    logic [3:0]           len_q;
    logic [3:0]           beat_q;
    logic [1:0]           burst_q;
    logic [1:0]           resp_q;
    logic [ADDR_BITS-1:0] idx_q;
    logic [ADDR_BITS-1:0] idx_nxt;
    logic [ADDR_BITS-1:0] idx_inc;
    logic [ADDR_BITS-1:0] wrap_mask;
    logic [ADDR_BITS-1:0] rd_idx;
    logic [ADDR_BITS-1:0] ar_idx;
    logic [1:0]           ar_resp;
    logic                 wrap_ok;
    logic                 last_beat;
    logic                 load_en;
    logic                 load_zero;
    logic [3:0]           awid_q;
    logic                 unused_ok;

    // ROM contents: zero-filled
    initial begin
        for (int i = 0; i < (1 << ADDR_BITS); i++) rom_mem[i] = 32'd0;
    end

    assign ar_idx    = araddr[ADDR_BITS+1:2];
    assign ar_resp   = (arsize != 3'b010) ? 2'b11 : (arburst == 2'b11) ? 2'b10 : 2'b00;
    assign last_beat = (beat_q == len_q);
    assign rid       = id_q;
    assign rresp     = resp_q;
    assign rlast     = rvalid && last_beat;
    assign bid       = awid_q;
    assign bresp     = 2'b10;
    assign unused_ok = ^{araddr, arlock, arcache, arprot, awaddr, awlen, awsize, awburst,
                         awlock, awcache, awprot, wid, wdata, wstrb};

    // Next beat index: FIXED holds, legal WRAP stays inside its aligned block, others increment
    always_comb begin
        idx_inc   = idx_q + ADDR_BITS'(1);
        wrap_mask = ADDR_BITS'(len_q);
        wrap_ok   = (burst_q == 2'b10) &&
                    (len_q == 4'd1 || len_q == 4'd3 || len_q == 4'd7 || len_q == 4'd15);
        if (burst_q == 2'b00)
            idx_nxt = idx_q;
        else if (wrap_ok)
            idx_nxt = (idx_q & ~wrap_mask) | (idx_inc & wrap_mask);
        else
            idx_nxt = idx_inc;
    end

    // Read FSM next state, handshake outputs and ROM read-ahead control
    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        load_en     = 1'b0;
        load_zero   = (resp_q == 2'b11);
        rd_idx      = idx_q;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) begin
                    if (LATENCY == 1) begin
                        r_state_nxt = R_BURST;
                        load_en     = 1'b1;
                        load_zero   = (arsize != 3'b010);
                        rd_idx      = ar_idx;
                    end else begin
                        r_state_nxt = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (lat_cnt == 4'd1) begin
                    r_state_nxt = R_BURST;
                    load_en     = 1'b1;
                end
            end
            R_BURST: begin
                rvalid = 1'b1;
                if (rready) begin
                    if (last_beat) begin
                        r_state_nxt = R_IDLE;
                    end else begin
                        load_en = 1'b1;
                        rd_idx  = idx_nxt;
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Read state, burst context and registered ROM data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            lat_cnt <= 4'd0;
            id_q    <= 4'd0;
            len_q   <= 4'd0;
            beat_q  <= 4'd0;
            burst_q <= 2'b00;
            resp_q  <= 2'b00;
            idx_q   <= '0;
            rdata   <= 32'd0;
        end else begin
            r_state <= r_state_nxt;
            if (r_state == R_IDLE && arvalid) begin
                id_q    <= arid;
                len_q   <= arlen;
                burst_q <= arburst;
                resp_q  <= ar_resp;
                idx_q   <= ar_idx;
                beat_q  <= 4'd0;
                lat_cnt <= 4'(LATENCY - 1);
            end
            if (r_state == R_WAIT) lat_cnt <= lat_cnt - 4'd1;
            if (r_state == R_BURST && rready && !last_beat) begin
                idx_q  <= idx_nxt;
                beat_q <= beat_q + 4'd1;
            end
            if (load_en) rdata <= load_zero ? 32'd0 : rom_mem[rd_idx];
        end
    end

    // Write FSM next state and outputs: accept address, sink data, answer SLVERR
    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && wlast) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write state and captured write ID
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awid_q  <= 4'd0;
        end else begin
            w_state <= w_state_nxt;
            if (w_state == W_IDLE && awvalid) awid_q <= awid;
        end
    end

endmodule

// File: tb/tb_axi_inst_rom_slave.sv
// tb/tb_axi_inst_rom_slave.sv - scoreboard bench for the instruction ROM AXI slave
module tb_axi_inst_rom_slave;

  localparam int AB = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;
  logic        awvalid, awready;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_inst_rom_slave #(.ADDR_BITS(AB), .LATENCY(2), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(2'b00), .arcache(4'h0), .arprot(3'b000),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(32'h0000_0040), .awlen(4'd2), .awsize(3'b010), .awburst(2'b01),
    .awlock(2'b00), .awcache(4'h0), .awprot(3'b000),
    .awvalid(awvalid), .awready(awready),
    .wid(4'd9), .wdata(32'hDEAD_BEEF), .wstrb(4'hF), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  function automatic logic [31:0] rom_val(int i);
    return 32'(i * 4);
  endfunction

  // Reference beat list for one read burst
  task automatic push_expected(input logic [3:0] id, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst);
    int start, idx, base;
    beat_t b;
    start = int'(addr[AB+1:2]);
    for (int k = 0; k <= len; k++) begin
      if (burst == 2'b00) idx = start;
      else if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
        base = start - (start % (len + 1));
        idx  = base + ((start - base + k) % (len + 1));
      end else idx = (start + k) % (1 << AB);
      b.resp = (size != 3'b010) ? 2'b11 : (burst == 2'b11) ? 2'b10 : 2'b00;
      b.data = (b.resp == 2'b11) ? 32'd0 : rom_val(idx);
      b.last = (k == len);
      b.id   = id;
      exp_q.push_back(b);
    end
  endtask

  // Called just after a negedge; returns at the negedge following the AR handshake edge
  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst);
    total++;
    if (arready !== 1'b1) begin
      bad++;
      $display("FAIL ar_ready_before_issue: got %b want 1", arready);
    end
    arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    push_expected(id, addr, len, size, burst);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Drain the scoreboard; pattern 0 keeps rready high, 1 toggles it 1,0,1,0
  task automatic collect(input int pattern, input string name);
    int cyc = 0;
    beat_t e;
    while (exp_q.size() > 0 && cyc < 200) begin
      rready = (pattern == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (rvalid === 1'b1) begin
        e = exp_q[0];
        total++;
        if ({rdata, rresp, rlast, rid} !== e) begin
          bad++;
          $display("FAIL %s beat: got data=%h resp=%b last=%b id=%h want data=%h resp=%b last=%b id=%h",
                   name, rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
        end
        if (rready) void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    rready = 1'b1;
    total++;
    if (exp_q.size() != 0 || rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++;
      $display("FAIL %s end: left=%0d rvalid=%b arready=%b want left=0 rvalid=0 arready=1",
               name, exp_q.size(), rvalid, arready);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    total++;
    if ({arready, rvalid, rlast, rid, rdata, rresp, awready, wready, bvalid, bid, bresp} !==
        {1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0, 2'b10}) begin
      bad++;
      $display("FAIL reset_values: got ar=%b rv=%b rl=%b rid=%h rd=%h rr=%b aw=%b w=%b bv=%b bid=%h br=%b",
               arready, rvalid, rlast, rid, rdata, rresp, awready, wready, bvalid, bid, bresp);
    end
  endtask

  // Cycle-exact INCR burst: AR at cycle 0, beats on cycles 2..9, arready back at 10
  task automatic test_incr_burst();
    beat_t e;
    logic exp_v;
    rready = 1'b1;
    issue_ar(4'd3, 32'h1FC0_0000, 7, 3'b010, 2'b01);
    for (int c = 1; c <= 10; c++) begin
      exp_v = (c >= 2 && c <= 9);
      total++;
      if (rvalid !== exp_v || arready !== (c == 10) || rlast !== (c == 9)) begin
        bad++;
        $display("FAIL incr_timing c%0d: got rvalid=%b arready=%b rlast=%b want %b %b %b",
                 c, rvalid, arready, rlast, exp_v, (c == 10), (c == 9));
      end
      if (rvalid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({rdata, rresp, rid} !== {e.data, e.resp, e.id}) begin
          bad++;
          $display("FAIL incr_data c%0d: got %h/%b/%h want %h/%b/%h",
                   c, rdata, rresp, rid, e.data, e.resp, e.id);
        end
      end
      @(negedge clk);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL incr_count: got %0d beats left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rready_toggle();
    issue_ar(4'd3, 32'h1FC0_0000, 7, 3'b010, 2'b01);
    collect(1, "toggle");
  endtask

  task automatic test_wrap();
    issue_ar(4'd1, 32'h0000_0008, 3, 3'b010, 2'b10);
    collect(0, "wrap");
  endtask

  task automatic test_decerr();
    issue_ar(4'd2, 32'h0000_0000, 1, 3'b000, 2'b01);
    collect(0, "decerr");
    issue_ar(4'd4, 32'h0000_0014, 0, 3'b010, 2'b01);
    collect(0, "after_decerr");
  endtask

  task automatic test_burst_types();
    issue_ar(4'd7, 32'h0000_0040, 2, 3'b010, 2'b00);
    collect(0, "fixed");
    issue_ar(4'd8, 32'h0000_3FFC, 1, 3'b010, 2'b11);
    collect(0, "slverr_wrap_index");
    issue_ar(4'd9, 32'h0000_0024, 2, 3'b010, 2'b10);
    collect(0, "wrap_len2_incr");
    issue_ar(4'd10, 32'h0000_0000, 0, 3'b001, 2'b11);
    collect(0, "decerr_over_slverr");
  endtask

  // AW then three W beats; leaves the B response pending when hold_b is set
  task automatic do_write(input logic hold_b);
    awid = 4'd9; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wvalid = 1'b1; wlast = (i == 2);
      total++;
      if (wready !== 1'b1 || bvalid !== 1'b0) begin
        bad++;
        $display("FAIL write_beat%0d: got wready=%b bvalid=%b want 1 0", i, wready, bvalid);
      end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    total++;
    if ({bvalid, bid, bresp, wready} !== {1'b1, 4'd9, 2'b10, 1'b0}) begin
      bad++;
      $display("FAIL write_resp: got bvalid=%b bid=%h bresp=%b wready=%b want 1 9 10 0",
               bvalid, bid, bresp, wready);
    end
    if (!hold_b) begin
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      total++;
      if (bvalid !== 1'b0 || awready !== 1'b1) begin
        bad++;
        $display("FAIL write_done: got bvalid=%b awready=%b want 0 1", bvalid, awready);
      end
    end
  endtask

  task automatic test_write();
    do_write(1'b0);
    issue_ar(4'd5, 32'h0000_0040, 3, 3'b010, 2'b01);
    collect(0, "after_write");
  endtask

  task automatic test_reset_mid_burst();
    do_write(1'b1);
    rready = 1'b1;
    issue_ar(4'd5, 32'h0000_0000, 7, 3'b010, 2'b01);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    total++;
    if ({rvalid, arready, bvalid, awready} !== 4'b0101) begin
      bad++;
      $display("FAIL reset_mid_burst: got rvalid=%b arready=%b bvalid=%b awready=%b want 0 1 0 1",
               rvalid, arready, bvalid, awready);
    end
    issue_ar(4'd6, 32'h0000_0100, 3, 3'b010, 2'b01);
    collect(0, "post_reset_burst");
  endtask

  initial begin
    rst = 1'b1;
    arid = 4'd0; araddr = 32'd0; arlen = 4'd0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
    rready = 1'b0;
    awid = 4'd0; awvalid = 1'b0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    #1;
    for (int i = 0; i < (1 << AB); i++) dut.rom_mem[i] = rom_val(i);
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_incr_burst();
    test_rready_toggle();
    test_wrap();
    test_decerr();
    test_burst_types();
    test_write();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
